// File: rtl/te_block_packer_if.sv
// Block output bus from the trace block packer toward the E-Trace encoder.
// The packer drives the head of its block FIFO. The encoder answers with ready_i.
interface te_block_packer_if #(
  parameter int XLEN        = 64,
  parameter int IRETIRE_LEN = 32,
  parameter int ITYPE_LEN   = 3,
  parameter int PRIV_LEN    = 2
);
  logic                   valid_o;
  logic                   ready_i;
  logic [XLEN-1:0]        iaddr_o;
  logic [IRETIRE_LEN-1:0] iretire_o;
  logic                   ilastsize_o;
  logic [ITYPE_LEN-1:0]   itype_o;
  logic [XLEN-1:0]        cause_o;
  logic [XLEN-1:0]        tval_o;
  logic [PRIV_LEN-1:0]    priv_o;

  // Packer side.
  modport master (
    output valid_o, iaddr_o, iretire_o, ilastsize_o, itype_o, cause_o, tval_o, priv_o,
    input  ready_i
  );

  // Encoder side.
  modport slave (
    input  valid_o, iaddr_o, iretire_o, ilastsize_o, itype_o, cause_o, tval_o, priv_o,
    output ready_i
  );
endinterface

// File: rtl/te_block_packer.sv
// te_block_packer: packs up to NRET classified retired instructions per cycle into
// E-Trace instruction blocks and queues closed blocks in a DEPTH-entry registered FIFO.
// Optional feature macro: TE_PACKER_DROP_CNT_EN adds drop_cnt_o, a saturating count of
// dropped blocks. When the macro is undefined, only the sticky overflow_o reports loss.
module te_block_packer #(
  parameter int NRET        = 2,
  parameter int XLEN        = 64,
  parameter int IRETIRE_LEN = 32,
  parameter int ITYPE_LEN   = 3,
  parameter int PRIV_LEN    = 2,
  parameter int MAX_IRETIRE = 64,
  parameter int DEPTH       = 8
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NRET-1:0]                valid_i,
  input  logic [NRET-1:0][XLEN-1:0]      iaddr_i,
  input  logic [NRET-1:0]                compressed_i,
  input  logic [NRET-1:0][ITYPE_LEN-1:0] itype_i,
  input  logic [XLEN-1:0]                cause_i,
  input  logic [XLEN-1:0]                tval_i,
  input  logic [PRIV_LEN-1:0]            priv_i,
  te_block_packer_if.master              enc,
  output logic                           fifo_full_o,
`ifdef TE_PACKER_DROP_CNT_EN
  output logic [15:0]                    drop_cnt_o,
`endif
  output logic                           overflow_o
);

  localparam int AW = $clog2(DEPTH);
  // One spare bit, so that count + 2 cannot wrap when MAX_IRETIRE is near 2**IRETIRE_LEN.
  localparam int CW = IRETIRE_LEN + 1;

  typedef struct packed {
    logic [XLEN-1:0]        iaddr;
    logic [IRETIRE_LEN-1:0] iretire;
    logic                   ilastsize;
    logic [ITYPE_LEN-1:0]   itype;
    logic [XLEN-1:0]        cause;
    logic [XLEN-1:0]        tval;
    logic [PRIV_LEN-1:0]    priv;
  } blk_t;

  // Open block. A count of zero means that no block is open.
  logic [CW-1:0]   r_count;
  logic [XLEN-1:0] r_start;
  logic            r_last;

  // FIFO storage and bookkeeping.
  blk_t            r_mem [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [AW:0]     r_occ;
  blk_t            r_held;
  logic            r_overflow;

  logic [CW-1:0]   w_count;
  logic [XLEN-1:0] w_start;
  logic            w_last;
  blk_t            w_blk    [NRET];
  logic [NRET-1:0] w_cls;
  logic            w_pop;
  logic [AW:0]     w_cap;
  logic [AW:0]     w_npush;
  logic [AW:0]     w_ndrop;
  logic [NRET-1:0] w_wr_en;
  logic [AW-1:0]   w_wr_idx [NRET];
  blk_t            w_head;

  // Walk the lanes oldest first: extend the open block and close it on an event or on the count limit.
  always_comb begin
    // NOTE: blocking assignments here form a lane-to-lane chain inside one cycle; every
    // variable gets a default first, so no latch is inferred.
    w_count = r_count;
    w_start = r_start;
    w_last  = r_last;
    w_cls   = '0;
    for (int k = 0; k < NRET; k++) begin
      w_blk[k] = '0;
      if (valid_i[k]) begin
        if (w_count == '0) w_start = iaddr_i[k];
        w_count = w_count + (compressed_i[k] ? CW'(1) : CW'(2));
        w_last  = ~compressed_i[k];
        if ((itype_i[k] != '0) || (w_count >= CW'(MAX_IRETIRE))) begin
          w_cls[k]           = 1'b1;
          w_blk[k].iaddr     = w_start;
          w_blk[k].iretire   = w_count[IRETIRE_LEN-1:0];
          w_blk[k].ilastsize = w_last;
          w_blk[k].itype     = itype_i[k];
          w_blk[k].priv      = priv_i;
          if ((itype_i[k] == ITYPE_LEN'(1)) || (itype_i[k] == ITYPE_LEN'(2))) begin
            w_blk[k].cause = cause_i;
            w_blk[k].tval  = tval_i;
          end
          w_count = '0;
        end
      end
    end
  end

  // Assign free FIFO slots to the closed blocks in lane order. Blocks that find no free slot are dropped.
  always_comb begin
    w_pop   = (r_occ != '0) && enc.ready_i;
    w_cap   = (AW+1)'(DEPTH) - r_occ + (AW+1)'(w_pop);
    w_npush = '0;
    w_ndrop = '0;
    for (int k = 0; k < NRET; k++) begin
      w_wr_en[k]  = 1'b0;
      w_wr_idx[k] = r_wptr + w_npush[AW-1:0];
      if (w_cls[k]) begin
        if (w_npush < w_cap) begin
          w_wr_en[k] = 1'b1;
          w_npush    = w_npush + 1'b1;
        end else begin
          w_ndrop    = w_ndrop + 1'b1;
        end
      end
    end
  end

  // Control state: open block, FIFO pointers, last popped block and sticky overflow.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_count    <= '0;
      r_start    <= '0;
      r_last     <= 1'b0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_occ      <= '0;
      r_held     <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_count    <= w_count;
      r_start    <= w_start;
      r_last     <= w_last;
      r_wptr     <= r_wptr + w_npush[AW-1:0];
      r_rptr     <= r_rptr + AW'(w_pop);
      r_occ      <= r_occ + w_npush - (AW+1)'(w_pop);
      r_overflow <= r_overflow | (w_ndrop != '0);
      if (w_pop) r_held <= r_mem[r_rptr];
    end
  end

  // Block storage. Only the slots that were assigned to a closed block are written.
  // NOTE: the storage has no reset. An entry is only read after it has been written,
  // and the empty-FIFO outputs come from r_held, which is reset.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < NRET; k++) begin
      if (w_wr_en[k]) r_mem[w_wr_idx[k]] <= w_blk[k];
    end
  end

`ifdef TE_PACKER_DROP_CNT_EN
  logic [15:0] r_drop_cnt;
  logic [16:0] w_drop_sum;
  assign w_drop_sum = 17'(r_drop_cnt) + 17'(w_ndrop);

  // Saturating count of dropped blocks.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_drop_cnt <= '0;
    else       r_drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
  end
  assign drop_cnt_o = r_drop_cnt;
`endif

  // The FIFO head drives the outputs. When the FIFO is empty, the last popped block drives them.
  assign w_head          = (r_occ != '0) ? r_mem[r_rptr] : r_held;
  assign enc.valid_o     = (r_occ != '0);
  assign enc.iaddr_o     = w_head.iaddr;
  assign enc.iretire_o   = w_head.iretire;
  assign enc.ilastsize_o = w_head.ilastsize;
  assign enc.itype_o     = w_head.itype;
  assign enc.cause_o     = w_head.cause;
  assign enc.tval_o      = w_head.tval;
  assign enc.priv_o      = w_head.priv;
  assign fifo_full_o     = (r_occ == (AW+1)'(DEPTH));
  assign overflow_o      = r_overflow;

endmodule

// File: tb/tb_te_block_packer.sv
// Self-checking bench for te_block_packer. Directed scenarios are followed by randomized
// traffic, and every cycle is compared against a queue-based model of blocks and FIFO contents.
module tb_te_block_packer;
  localparam int NRET = 2, XLEN = 64, IRL = 32, ITL = 3, PRL = 2, MAXR = 64, DEPTH = 8;

  logic                     clk_i = 1'b0;
  logic                     rst_i;
  logic [NRET-1:0]          valid_i, compressed_i;
  logic [NRET-1:0][XLEN-1:0] iaddr_i;
  logic [NRET-1:0][ITL-1:0] itype_i;
  logic [XLEN-1:0]          cause_i, tval_i;
  logic [PRL-1:0]           priv_i;
  logic                     fifo_full_o, overflow_o;
`ifdef TE_PACKER_DROP_CNT_EN
  logic [15:0]              drop_cnt_o;
`endif

  te_block_packer_if #(.XLEN(XLEN), .IRETIRE_LEN(IRL), .ITYPE_LEN(ITL), .PRIV_LEN(PRL)) bus ();

  te_block_packer #(.NRET(NRET), .XLEN(XLEN), .IRETIRE_LEN(IRL), .ITYPE_LEN(ITL),
                    .PRIV_LEN(PRL), .MAX_IRETIRE(MAXR), .DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .iaddr_i(iaddr_i),
    .compressed_i(compressed_i), .itype_i(itype_i), .cause_i(cause_i), .tval_i(tval_i),
    .priv_i(priv_i), .enc(bus.master), .fifo_full_o(fifo_full_o),
`ifdef TE_PACKER_DROP_CNT_EN
    .drop_cnt_o(drop_cnt_o),
`endif
    .overflow_o(overflow_o));

  always #5 clk_i = ~clk_i;

  // Scoreboard counters.
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: the open block is a list of instructions, and the FIFO is a queue of packed blocks.
  typedef struct { logic [63:0] addr; bit comp; } instr_t;
  instr_t        m_open[$];
  logic [255:0]  m_fifo[$];
  logic [255:0]  m_last;
  bit            m_ovf;
  int            m_drops;

  function automatic logic [255:0] pk(logic [63:0] a, logic [31:0] r, logic l, logic [2:0] t,
                                      logic [63:0] c, logic [63:0] tv, logic [1:0] p);
    return {26'b0, a, r, l, t, c, tv, p};
  endfunction

  function automatic logic [255:0] dut_head();
    return pk(bus.iaddr_o, bus.iretire_o, bus.ilastsize_o, bus.itype_o, bus.cause_o,
              bus.tval_o, bus.priv_o);
  endfunction

  task automatic model_reset();
    m_open.delete(); m_fifo.delete(); m_last = '0; m_ovf = 0; m_drops = 0;
  endtask

  // Check the current outputs, advance the model by one clock with the present inputs, and settle.
  task automatic step();
    logic [255:0] closed[$];
    instr_t ins;
    int     sum;
    bit     pop;
    check("valid", 256'(bus.valid_o), 256'(m_fifo.size() != 0));
    check("head", dut_head(), (m_fifo.size() != 0) ? m_fifo[0] : m_last);
    check("full", 256'(fifo_full_o), 256'(m_fifo.size() == DEPTH));
    check("overflow", 256'(overflow_o), 256'(m_ovf));
`ifdef TE_PACKER_DROP_CNT_EN
    check("drop_cnt", 256'(drop_cnt_o), 256'((m_drops > 65535) ? 65535 : m_drops));
`endif
    pop = (m_fifo.size() != 0) && bus.ready_i;
    for (int k = 0; k < NRET; k++) begin
      if (valid_i[k]) begin
        ins.addr = iaddr_i[k]; ins.comp = compressed_i[k];
        m_open.push_back(ins);
        sum = 0;
        foreach (m_open[j]) sum += m_open[j].comp ? 1 : 2;
        if (itype_i[k] != 0 || sum >= MAXR) begin
          closed.push_back(pk(m_open[0].addr, 32'(sum), ~m_open[m_open.size()-1].comp, itype_i[k],
                              (itype_i[k] inside {1, 2}) ? cause_i : 64'h0,
                              (itype_i[k] inside {1, 2}) ? tval_i : 64'h0, priv_i));
          m_open.delete();
        end
      end
    end
    @(posedge clk_i);
    if (rst_i) model_reset();
    else begin
      if (pop) m_last = m_fifo.pop_front();
      foreach (closed[i]) begin
        if (m_fifo.size() < DEPTH) m_fifo.push_back(closed[i]);
        else begin m_ovf = 1; m_drops++; end
      end
    end
    #1;
  endtask

  task automatic idle();
    valid_i = '0; iaddr_i = '0; compressed_i = '0; itype_i = '0;
  endtask

  task automatic lane(input int k, input logic [63:0] a, input bit c, input logic [2:0] t);
    valid_i[k] = 1'b1; iaddr_i[k] = a; compressed_i[k] = c; itype_i[k] = t;
  endtask

  task automatic drain();
    idle();
    bus.ready_i = 1'b1;
    repeat (DEPTH + 2) step();
  endtask

  task automatic head_is(input string tag, input logic [63:0] a, input logic [31:0] r,
                         input logic l, input logic [2:0] t);
    check(tag, 256'({bus.valid_o, bus.iaddr_o, bus.iretire_o, bus.ilastsize_o, bus.itype_o}),
          256'({1'b1, a, r, l, t}));
  endtask

  initial begin
    int n;
    rst_i = 1'b1; bus.ready_i = 1'b1; idle();
    cause_i = '0; tval_i = '0; priv_i = '0;
    // Hold reset for two cycles. All outputs must read zero.
    repeat (2) @(posedge clk_i);
    #1;
    model_reset();
    check("rst_valid", 256'(bus.valid_o), 256'(0));
    check("rst_flags", 256'({fifo_full_o, overflow_o}), 256'(0));
    check("rst_data", dut_head(), 256'(0));
    rst_i = 1'b0;

    // A block spans two cycles and is closed by a taken branch.
    lane(0, 64'h1000, 0, 0); step();
    idle(); lane(0, 64'h1004, 1, 0); lane(1, 64'h1006, 0, 5); step();
    idle();
    head_is("t2_block", 64'h1000, 5, 1, 5);
    drain();

    // Two blocks close in the same cycle.
    lane(0, 64'h2000, 0, 4); lane(1, 64'h2004, 1, 5); step();
    idle();
    head_is("t3_first", 64'h2000, 2, 1, 4);
    step();
    head_is("t3_second", 64'h2004, 1, 0, 5);
    drain();

    // The count limit closes the block, and the next instruction opens a new block.
    for (int i = 0; i < 32; i++) begin
      idle(); lane(0, 64'h3000 + 64'(4 * i), 0, 0); step();
    end
    idle();
    head_is("t4_limit", 64'h3000, 64, 1, 0);
    lane(0, 64'h3080, 0, 5); step();
    idle();
    head_is("t4_next", 64'h3080, 2, 1, 5);
    drain();

    // A trap block carries cause, tval and priv.
    lane(0, 64'h4000, 0, 1); cause_i = 64'd2; tval_i = 64'hDEAD; priv_i = 2'd3; step();
    idle(); cause_i = '0; tval_i = '0; priv_i = '0;
    check("t6_trap", 256'({bus.iretire_o, bus.cause_o, bus.tval_o, bus.priv_o}),
          256'({32'd2, 64'd2, 64'hDEAD, 2'd3}));
    drain();

    // Overflow: nine blocks arrive while the encoder stalls, then exactly eight drain in order.
    bus.ready_i = 1'b0;
    for (int i = 0; i < 9; i++) begin
      idle(); lane(0, 64'h5000 + 64'(4 * i), 0, 4); step();
    end
    idle(); step();
    check("t5_full", 256'(fifo_full_o), 256'(1));
    check("t5_ovf", 256'(overflow_o), 256'(1));
`ifdef TE_PACKER_DROP_CNT_EN
    check("t5_drop_cnt", 256'(drop_cnt_o), 256'(1));
`endif
    bus.ready_i = 1'b1;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.valid_o) begin
        check("t5_order", 256'(bus.iaddr_o), 256'(64'h5000 + 64'(4 * n)));
        n++;
      end
      step();
    end
    check("t5_drained", 256'(n), 256'(8));

    // Reset in the middle of a block discards the partial block and clears overflow.
    lane(0, 64'h6000, 0, 0); step();
    idle(); rst_i = 1'b1; step();
    rst_i = 1'b0;
    check("rst_ovf_clr", 256'(overflow_o), 256'(0));
    lane(0, 64'h7000, 0, 5); step();
    idle();
    head_is("midrst_block", 64'h7000, 2, 1, 5);
    drain();

    // Randomized traffic with variable backpressure and occasional resets.
    for (int c = 0; c < 4000; c++) begin
      for (int k = 0; k < NRET; k++) begin
        valid_i[k]      = ($urandom_range(0, 3) != 0);
        iaddr_i[k]      = {32'h0, $urandom} & ~64'h1;
        compressed_i[k] = 1'($urandom_range(0, 1));
        itype_i[k]      = ($urandom_range(0, 9) < 8) ? 3'd0 : 3'($urandom_range(1, 6));
      end
      cause_i     = {$urandom, $urandom};
      tval_i      = {$urandom, $urandom};
      priv_i      = 2'($urandom_range(0, 3));
      bus.ready_i = ($urandom_range(0, 9) < (((c % 800) < 400) ? 8 : 2));
      rst_i       = ($urandom_range(0, 599) == 0);
      step();
    end
    rst_i = 1'b0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
